// File: rtl/tl_rx_credits_received_tracker.sv
// tl_rx_credits_received_tracker: per-class CREDITS_RECEIVED counters for the TL RX write path
module tl_rx_credits_received_tracker #(
  parameter int HDR_CREDS_WIDTH       = 12,
  parameter int DATA_CREDS_WIDTH      = 16,
  parameter int BUFFER_IN_DW_WIDTH    = 10,
  parameter int BUFFER_IN_CREDS_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             tlp_valid,
  output logic                             tlp_ready,
  input  logic [1:0]                       fc_type,
  input  logic                             has_data,
  input  logic [BUFFER_IN_DW_WIDTH-1:0]    buffer_in_dw,
  input  logic [5:0]                       hdr_scale_vec,
  input  logic [5:0]                       data_scale_vec,
  input  logic                             tlp_commit,
  input  logic                             tlp_discard,
  output logic                             pending,
  output logic [HDR_CREDS_WIDTH-1:0]       rcv_hdr,
  output logic [DATA_CREDS_WIDTH-1:0]      rcv_data,
  output logic [BUFFER_IN_CREDS_WIDTH-1:0] buffer_in_creds,
  output logic [1:0]                       hdr_scale,
  output logic [1:0]                       data_scale
);
  localparam logic [HDR_CREDS_WIDTH-1:0]  HM8  = HDR_CREDS_WIDTH'(255);
  localparam logic [HDR_CREDS_WIDTH-1:0]  HM10 = HDR_CREDS_WIDTH'(1023);
  localparam logic [DATA_CREDS_WIDTH-1:0] DM12 = DATA_CREDS_WIDTH'(4095);
  localparam logic [DATA_CREDS_WIDTH-1:0] DM14 = DATA_CREDS_WIDTH'(16383);
  localparam logic [BUFFER_IN_DW_WIDTH:0] R3   = 3;
  localparam logic [BUFFER_IN_DW_WIDTH:0] R15  = 15;
  localparam logic [BUFFER_IN_DW_WIDTH:0] R63  = 63;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t                             state, state_nxt;
  logic [1:0]                         cls;
  logic [HDR_CREDS_WIDTH-1:0]         hdr_cnt [3];
  logic [DATA_CREDS_WIDTH-1:0]        data_cnt [3];
  logic                               accept, commit;
  logic [1:0]                         hs_in, ds_in;
  logic [BUFFER_IN_DW_WIDTH:0]        len;
  logic [BUFFER_IN_CREDS_WIDTH-1:0]   creds_in;
  logic [HDR_CREDS_WIDTH-1:0]         hmask;
  logic [DATA_CREDS_WIDTH-1:0]        dmask;
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    if (state == IDLE) begin
      accept    = tlp_valid && fc_type != 2'b11;
      state_nxt = accept ? PENDING : IDLE;
    end else begin
      commit    = tlp_commit && !tlp_discard;
      state_nxt = (tlp_commit || tlp_discard) ? IDLE : PENDING;
    end
  end
  always_comb begin
    hs_in    = fc_type == 2'd2 ? hdr_scale_vec[5:4] : fc_type == 2'd1 ? hdr_scale_vec[3:2] : hdr_scale_vec[1:0];
    ds_in    = fc_type == 2'd2 ? data_scale_vec[5:4] : fc_type == 2'd1 ? data_scale_vec[3:2] : data_scale_vec[1:0];
    // a zero length field with payload encodes the maximum 1024 DW
    len      = {buffer_in_dw == '0, buffer_in_dw};
    creds_in = !has_data ? '0 :
               ds_in == 2'b11 ? BUFFER_IN_CREDS_WIDTH'((len + R63) >> 6) :
               ds_in == 2'b10 ? BUFFER_IN_CREDS_WIDTH'((len + R15) >> 4) :
                                BUFFER_IN_CREDS_WIDTH'((len + R3) >> 2);
    hmask    = hdr_scale == 2'b11 ? '1 : hdr_scale == 2'b10 ? HM10 : HM8;
    dmask    = data_scale == 2'b11 ? '1 : data_scale == 2'b10 ? DM14 : DM12;
    rcv_hdr  = (cls == 2'd2 ? hdr_cnt[2] : cls == 2'd1 ? hdr_cnt[1] : hdr_cnt[0]) & hmask;
    rcv_data = (cls == 2'd2 ? data_cnt[2] : cls == 2'd1 ? data_cnt[1] : data_cnt[0]) & dmask;
  end
  assign tlp_ready = state == IDLE;
  assign pending   = state == PENDING;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state           <= IDLE;
      cls             <= '0;
      hdr_scale       <= '0;
      data_scale      <= '0;
      buffer_in_creds <= '0;
      for (int i = 0; i < 3; i++) begin
        hdr_cnt[i]  <= '0;
        data_cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        cls             <= fc_type;
        hdr_scale       <= hs_in;
        data_scale      <= ds_in;
        buffer_in_creds <= creds_in;
      end
      // counters wrap at the width implied by the scale latched for this TLP
      for (int i = 0; i < 3; i++)
        if (commit && cls == 2'(i)) begin
          hdr_cnt[i]  <= (hdr_cnt[i] + 1'b1) & hmask;
          data_cnt[i] <= (data_cnt[i] + DATA_CREDS_WIDTH'(buffer_in_creds)) & dmask;
        end
    end
  end
endmodule
